// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port data memory between the core MEM stage (C) and the
// debug/program-loader port (D). Accesses are serialized as ACC/RESP pairs.
// Byte addresses are validated. Read data returns two cycles after the request
// is sampled.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   c_req/we/addr/wdata  core request (held until c_gnt)
//   c_gnt                one-cycle pulse when the core access is issued
//   c_rvalid/rdata/err   core completion; c_rdata holds until the next c_rvalid
//   d_*                  debug-port equivalents, plus d_lock (sampled with d_req)
//   m_en/we/addr/wdata   memory strobe and request fields
//   m_rdata              memory read data, one cycle after m_en
//   busy                 arbiter is in ACC or RESP
//
// state | meaning
// IDLE  | arbitration point, nothing in flight
// ACC   | owner's access presented to memory, owner's gnt asserted
// RESP  | owner's completion reported; also an arbitration point
module mem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            own_d;
    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [CW-1:0]   starve_cnt;
    logic            lock_flag;
    logic [31:0]     c_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            arb_pt;
    logic            any_req;
    logic            win_d;
    logic            starved;
    logic            addr_ok;
    logic [31:0]     resp_data;

    assign any_req   = c_req | d_req;
    assign starved   = (starve_cnt == CW'(STARVE_LIMIT));
    assign addr_ok   = (lat_addr[1:0] == 2'b00) && (lat_addr[31:ADDR_W+2] == '0);
    // Rejected accesses and writes report zero data.
    assign resp_data = (addr_ok && !lat_we) ? m_rdata : 32'h0;
    assign m_addr    = lat_addr[ADDR_W+1:2];
    assign m_wdata   = lat_wdata;

    always_comb begin
        win_d = 1'b0;
        if (lock_flag && d_req) begin
            win_d = 1'b1;
        end else if (c_req && d_req && starved) begin
            win_d = 1'b1;
        end else if (c_req) begin
            win_d = 1'b0;
        end else begin
            win_d = d_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arb_pt    = 1'b0;
        busy      = 1'b0;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        c_err     = 1'b0;
        d_err     = 1'b0;
        c_rdata   = c_rdata_q;
        d_rdata   = d_rdata_q;
        case (state)
            IDLE: begin
                arb_pt = 1'b1;
                if (any_req) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                busy      = 1'b1;
                c_gnt     = ~own_d;
                d_gnt     = own_d;
                m_en      = addr_ok;
                m_we      = addr_ok & lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                busy     = 1'b1;
                arb_pt   = 1'b1;
                c_rvalid = ~own_d;
                d_rvalid = own_d;
                c_err    = ~own_d & ~addr_ok;
                d_err    = own_d & ~addr_ok;
                if (own_d) begin
                    d_rdata = resp_data;
                end else begin
                    c_rdata = resp_data;
                end
                state_nxt = any_req ? ACC : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_d      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            starve_cnt <= '0;
            lock_flag  <= 1'b0;
            c_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (c_rvalid) begin
                c_rdata_q <= resp_data;
            end
            if (d_rvalid) begin
                d_rdata_q <= resp_data;
            end
            if (arb_pt) begin
                if (any_req) begin
                    own_d     <= win_d;
                    lat_we    <= win_d ? d_we    : c_we;
                    lat_addr  <= win_d ? d_addr  : c_addr;
                    lat_wdata <= win_d ? d_wdata : c_wdata;
                end
                if (any_req && win_d) begin
                    starve_cnt <= '0;
                    lock_flag  <= d_lock;
                end else if (c_req) begin
                    lock_flag  <= 1'b0;
                    if (!d_req) begin
                        starve_cnt <= '0;
                    end else if (!starved) begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                end else begin
                    starve_cnt <= '0;
                    lock_flag  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int ADDR_W = 5;
    localparam int LIMIT  = 4;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst;
    logic              c_req, c_we, d_req, d_we, d_lock;
    logic [31:0]       c_addr, c_wdata, d_addr, d_wdata;
    logic              c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0]       c_rdata, d_rdata;
    logic              m_en, m_we, busy;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata, m_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // External memory array: registered read, write on m_en & m_we.
    logic [31:0] mem [DEPTH];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    // Transaction-level reference: what is granted in each cycle and what the
    // completion in the following cycle must report.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_init = 1'b0;
    bit          e_gv, e_gd, e_en, e_we;
    int          e_maddr;
    logic [31:0] e_wdata;
    bit          e_rv, e_rd, e_err;
    logic [31:0] e_rdata, hold_c, hold_d;
    bit          p_v, p_d, p_err;
    logic [31:0] p_data;
    int          s_cnt;
    bit          l_flag;

    always @(posedge clk or posedge rst) begin
        bit          arb, any, wd, we_s, ok;
        logic [31:0] a, wdat;
        int          idx;
        if (rst) begin
            if (!ref_init) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
                ref_init = 1'b1;
            end
            e_gv = 0; e_gd = 0; e_en = 0; e_we = 0; e_maddr = 0; e_wdata = 0;
            e_rv = 0; e_rd = 0; e_err = 0; e_rdata = 0;
            p_v = 0; p_d = 0; p_err = 0; p_data = 0;
            hold_c = 0; hold_d = 0; s_cnt = 0; l_flag = 0;
        end else begin
            arb = !e_gv;
            e_rv = p_v; e_rd = p_d; e_err = p_err; e_rdata = p_data;
            if (e_rv) begin
                if (e_rd) hold_d = e_rdata;
                else      hold_c = e_rdata;
            end
            e_gv = 0; p_v = 0;
            if (arb) begin
                any = c_req || d_req;
                if (l_flag && d_req)                         wd = 1;
                else if (c_req && d_req && s_cnt == LIMIT)   wd = 1;
                else if (c_req)                              wd = 0;
                else                                         wd = d_req;
                if (any && wd) begin
                    s_cnt = 0; l_flag = d_lock;
                end else if (c_req) begin
                    l_flag = 0;
                    s_cnt = d_req ? ((s_cnt < LIMIT) ? s_cnt + 1 : LIMIT) : 0;
                end else begin
                    s_cnt = 0; l_flag = 0;
                end
                if (any) begin
                    a    = wd ? d_addr  : c_addr;
                    we_s = wd ? d_we    : c_we;
                    wdat = wd ? d_wdata : c_wdata;
                    ok   = (a < 32'(DEPTH * 4)) && (a % 4 == 0);
                    idx  = int'(a / 4) % DEPTH;
                    e_gv = 1; e_gd = wd; e_en = ok; e_we = we_s;
                    e_maddr = idx; e_wdata = wdat;
                    p_v = 1; p_d = wd; p_err = !ok;
                    if (!ok) p_data = 0;
                    else if (we_s) begin
                        ref_mem[idx] = wdat;
                        p_data = 0;
                    end else p_data = ref_mem[idx];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("c_gnt",    32'(c_gnt),    32'(e_gv && !e_gd));
        check("d_gnt",    32'(d_gnt),    32'(e_gv && e_gd));
        check("m_en",     32'(m_en),     32'(e_gv && e_en));
        if (e_gv && e_en) begin
            check("m_addr", 32'(m_addr), 32'(e_maddr));
            check("m_we",   32'(m_we),   32'(e_we));
            if (e_we) check("m_wdata", m_wdata, e_wdata);
        end
        check("c_rvalid", 32'(c_rvalid), 32'(e_rv && !e_rd));
        check("d_rvalid", 32'(d_rvalid), 32'(e_rv && e_rd));
        check("c_err",    32'(c_err),    32'(e_rv && !e_rd && e_err));
        check("d_err",    32'(d_err),    32'(e_rv && e_rd && e_err));
        check("c_rdata",  c_rdata,       hold_c);
        check("d_rdata",  d_rdata,       hold_d);
        check("busy",     32'(busy),     32'(e_gv || e_rv));
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) cmp_model();
    endtask

    task automatic single(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit exp_en, input int exp_maddr,
                          input bit exp_err, input logic [31:0] exp_rdata, input string nm);
        edge1();
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; d_lock = 0; end
        else      begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wd; end
        step();
        edge1();
        c_req = 0; d_req = 0;
        step();
        check({nm, "_gnt"}, 32'(is_d ? d_gnt : c_gnt), 1);
        check({nm, "_m_en"}, 32'(m_en), 32'(exp_en));
        if (exp_en) begin
            check({nm, "_m_addr"}, 32'(m_addr), 32'(exp_maddr));
            check({nm, "_m_we"}, 32'(m_we), 32'(we));
        end
        edge1();
        step();
        check({nm, "_rvalid"}, 32'(is_d ? d_rvalid : c_rvalid), 1);
        check({nm, "_err"}, 32'(is_d ? d_err : c_err), 32'(exp_err));
        check({nm, "_rdata"}, is_d ? d_rdata : c_rdata, exp_rdata);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return $urandom;
        if (r == 1) return {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
        if (r == 2) return 32'h80 | {25'h0, 5'($urandom), 2'b00} | (32'($urandom_range(0, 1)) << 20);
        return {25'h0, 5'($urandom), 2'b00};
    endfunction

    bit cg, dg;
    int k;

    initial begin
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
        repeat (3) @(negedge clk);
        check("rst_strobes", {20'h0, c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err,
                              m_en, m_we, busy, 3'b0}, 32'h0);
        check("rst_m_addr",  32'(m_addr), 32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Single read of preloaded word 3.
        single(0, 0, 32'h0C, 32'h0, 1, 3, 0, 32'hDEADBEEF, "rd_w3");

        // D write then back-to-back read of word 31.
        edge1();
        d_req = 1; d_we = 1; d_addr = 32'h7C; d_wdata = 32'h12345678; d_lock = 0;
        step();
        edge1();
        d_we = 0;
        step();
        check("wr_gnt", 32'(d_gnt), 1);
        check("wr_m_addr", 32'(m_addr), 31);
        check("wr_m_we", 32'({m_en, m_we}), 32'b11);
        edge1();
        step();
        check("wr_rvalid", 32'({d_rvalid, d_err}), 32'b10);
        check("wr_rdata", d_rdata, 32'h0);
        edge1();
        d_req = 0;
        step();
        check("rd31_gnt", 32'({d_gnt, m_en, m_we}), 32'b110);
        edge1();
        step();
        check("rd31_rvalid", 32'(d_rvalid), 1);
        check("rd31_rdata", d_rdata, 32'h12345678);

        // Rejected addresses, then word 3 must be intact.
        single(0, 1, 32'h0E, 32'hBAD0BAD0, 0, 0, 1, 32'h0, "bad_0e");
        single(0, 0, 32'h80, 32'h0, 0, 0, 1, 32'h0, "bad_80");
        single(0, 0, 32'h0C, 32'h0, 1, 3, 0, 32'hDEADBEEF, "rd_w3_again");

        // Both requesting continuously: every fifth grant goes to D.
        edge1();
        c_req = 1; c_we = 0; c_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h24; d_lock = 0;
        k = 0;
        for (int cyc = 0; cyc < 80 && k < 15; cyc++) begin
            step();
            if (c_gnt || d_gnt) begin
                check("starve_order", 32'(d_gnt), 32'(k % 5 == 4));
                k++;
            end
            if (k < 15) edge1();
        end
        check("starve_grants", 32'(k), 15);
        edge1();
        c_req = 0; d_req = 0;
        step();
        edge1();
        step();

        // Locked D keeps the memory until it lets go.
        edge1();
        d_req = 1; d_we = 0; d_addr = 32'h40; d_lock = 1;
        k = 0;
        for (int cyc = 0; cyc < 80 && k < 7; cyc++) begin
            step();
            if (c_gnt || d_gnt) begin
                check("lock_order", 32'(c_gnt), 32'(k == 6));
                k++;
            end
            if (k < 7) begin
                edge1();
                if (k >= 1) begin c_req = 1; c_we = 0; c_addr = 32'h44; end
                if (k >= 6) begin d_req = 0; d_lock = 0; end
            end
        end
        check("lock_grants", 32'(k), 7);
        edge1();
        c_req = 0; d_req = 0;
        step();
        edge1();
        step();

        // Reset pulse during the ACC cycle of a C read.
        edge1();
        c_req = 1; c_we = 0; c_addr = 32'h0C;
        step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_gnt_en_busy", 32'({c_gnt, m_en, busy}), 32'b000);
        #1 rst = 1'b0;
        step();
        check("rst_mid_no_rvalid", 32'({c_rvalid, busy}), 32'b00);
        edge1();
        c_req = 0;
        step();
        check("rst_after_gnt", 32'(c_gnt), 1);
        edge1();
        step();
        check("rst_after_rvalid", 32'(c_rvalid), 1);
        check("rst_after_rdata", c_rdata, 32'hDEADBEEF);

        // Randomized traffic against the reference.
        cg = 0; dg = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            edge1();
            if (!c_req || cg) begin
                if ($urandom_range(0, 3) != 0) begin
                    c_req = 1; c_we = 1'($urandom); c_addr = rand_addr(); c_wdata = $urandom;
                end else c_req = 0;
            end
            if (!d_req || dg) begin
                if ($urandom_range(0, 3) != 0) begin
                    d_req = 1; d_we = 1'($urandom); d_addr = rand_addr(); d_wdata = $urandom;
                    d_lock = ($urandom_range(0, 7) == 0);
                end else begin
                    d_req = 0; d_lock = 0;
                end
            end
            step();
            cg = c_gnt;
            dg = d_gnt;
        end
        edge1();
        c_req = 0; d_req = 0; d_lock = 0;
        repeat (3) begin
            step();
            edge1();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
